// File: rtl/mac_pkg.sv
// Shared types and sizing helpers for the MAC sequencer and its result serializer.
package mac_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefResW  = 41;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StLoadA,
    StLoadB,
    StIssue,
    StDrain,
    StSend
  } state_e;

  // Number of whole bytes needed to carry a result of res_w bits.
  function automatic int unsigned calc_out_bytes(int unsigned res_w, int unsigned data_w);
    return (res_w + data_w - 1) / data_w;
  endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// Byte-wide valid/ready stream used for the operand input and the result output.
interface mac_sequencer_if
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/mac_result_serializer.sv
// Latches the final accumulator value and shifts it out MSB-first, one byte per handshake.
module mac_result_serializer
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned RES_W  = DefResW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [RES_W-1:0]  result,
  input  logic              valid,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  localparam int unsigned OUT_BYTES = calc_out_bytes(RES_W, DATA_W);
  localparam int unsigned ShW       = OUT_BYTES * DATA_W;
  localparam int unsigned CntW      = $clog2(OUT_BYTES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(OUT_BYTES - 1);

  logic [ShW-1:0]  shift_q;
  logic [CntW-1:0] cnt_q;
  logic            hs;

  assign hs   = valid & ready;
  assign last = hs & (cnt_q == CntLast);

  // Shifting zeros in means the register is empty again once every byte has gone.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      shift_q <= ShW'(result);
      cnt_q   <= '0;
    end else if (hs) begin
      shift_q <= shift_q << DATA_W;
      cnt_q   <= last ? '0 : cnt_q + 1'b1;
    end
  end

  assign data = shift_q[ShW-1 -: DATA_W];

endmodule

// File: rtl/mac_sequencer.sv
// Framed MAC controller: clear, collect COUNT operand pairs, issue, drain, serialise result.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int unsigned COUNT   = 8,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned RES_W   = DefResW,
  parameter int unsigned MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  mac_sequencer_if.slave    in_if,
  output logic              mac_clr,
  output logic              mac_en,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  input  logic [RES_W-1:0]  mac_result,
  mac_sequencer_if.master   out_if,
  output logic              busy,
  output logic              done
);

  localparam int unsigned SmpW  = $clog2(COUNT + 1);
  localparam int unsigned WaitW = $clog2(MAC_LAT + 1);
  localparam logic [SmpW-1:0]  SmpLast  = SmpW'(COUNT - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MAC_LAT - 1);

  state_e state_q, state_d;

  logic [SmpW-1:0]   smp_q;
  logic [WaitW-1:0]  wait_q;
  logic [DATA_W-1:0] mac_a_q, mac_b_q;
  logic              in_ready_q, in_ready_d;
  logic              mac_clr_q, mac_clr_d;
  logic              mac_en_q, mac_en_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              in_hs;
  logic              abort_hit;
  logic              smp_last;
  logic              wait_last;
  logic              ser_load;
  logic              ser_last;
  logic [DATA_W-1:0] ser_data;

  assign in_hs     = in_if.valid & in_ready_q;
  assign abort_hit = abort & (state_q != StIdle);
  assign smp_last  = smp_q == SmpLast;
  assign wait_last = wait_q == WaitLast;
  assign ser_load  = (state_q == StDrain) & wait_last & ~abort_hit;

  // State and registered outputs; outputs follow the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      mac_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      mac_clr_q   <= mac_clr_d;
      mac_en_q    <= mac_en_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start && !abort) state_d = StClear;
      StClear: state_d = StLoadA;
      StLoadA: if (in_hs) state_d = StLoadB;
      StLoadB: if (in_hs) state_d = StIssue;
      StIssue: state_d = smp_last ? StDrain : StLoadA;
      StDrain: if (wait_last) state_d = StSend;
      StSend:  if (ser_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort_hit) state_d = StIdle;
  end

  // An abort also clears the accumulator so a half-built sum never leaks into the next frame.
  always_comb begin
    in_ready_d  = (state_d == StLoadA) || (state_d == StLoadB);
    mac_clr_d   = (state_d == StClear) || abort_hit;
    mac_en_d    = state_d == StIssue;
    out_valid_d = state_d == StSend;
    busy_d      = state_d != StIdle;
    done_d      = ser_last && !abort_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      smp_q   <= '0;
      wait_q  <= '0;
      mac_a_q <= '0;
      mac_b_q <= '0;
    end else if (abort_hit) begin
      smp_q  <= '0;
      wait_q <= '0;
    end else begin
      if (state_q == StLoadA && in_hs) mac_a_q <= in_if.data;
      if (state_q == StLoadB && in_hs) mac_b_q <= in_if.data;
      if (state_q == StIssue) smp_q <= smp_last ? '0 : smp_q + 1'b1;
      if (state_q == StDrain) wait_q <= wait_last ? '0 : wait_q + 1'b1;
    end
  end

  mac_result_serializer #(
    .DATA_W (DATA_W),
    .RES_W  (RES_W)
  ) u_serializer (
    .clk    (clk),
    .rst    (rst),
    .clear  (abort_hit),
    .load   (ser_load),
    .result (mac_result),
    .valid  (out_valid_q),
    .ready  (out_if.ready),
    .data   (ser_data),
    .last   (ser_last)
  );

  assign in_if.ready  = in_ready_q;
  assign mac_clr      = mac_clr_q;
  assign mac_en       = mac_en_q;
  assign mac_a        = mac_a_q;
  assign mac_b        = mac_b_q;
  assign out_if.valid = out_valid_q;
  assign out_if.data  = ser_data;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
